controlador_porta: RTL and testbench
====================================

Name: controlador_porta

Overview:
- Sequencing FSM that commands the door LED animation block and consumes its open/closed indicators.
- Drives control_port (1 = close, 0 = open) and waits for port_a/port_f before advancing.
- Holds the door open for a dwell time and reopens on obstacle or open-button.
- Grants the elevator motor permission to move only when the door is confirmed closed.

Parameters:
- TEMPO_ABERTA, 8: dwell cycles the door stays fully open before auto-close; must be >= 1.
- TIMEOUT, 16: max cycles allowed in ABRINDO or FECHANDO without the matching indicator; must be >= 2.
- LARG_CONT, $clog2(max(TEMPO_ABERTA,TIMEOUT)+1): width of the shared down counter (derived).

Ports:
- clock_in  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- chegou_andar  input  1  one-cycle pulse: cabin stopped at a requested floor.
- botao_abrir  input  1  open-door button, level.
- botao_fechar  input  1  close-door button, level.
- obstaculo  input  1  door-path sensor, level, 1 = blocked.
- port_a  input  1  from animation block: door fully open.
- port_f  input  1  from animation block: door fully closed.
- control_port  output  1  to animation block: 1 = close, 0 = open.
- liberar_motor  output  1  1 = door closed and idle, motor may move.
- ocupado  output  1  1 in any state other than FECHADA.
- erro_porta  output  1  sticky fault flag.

Behaviour:
- All outputs are registered. States are FECHADA, ABRINDO, ABERTA, FECHANDO and FALHA.
- Reset (async assert, sync release): state FECHANDO, control_port=1, liberar_motor=0, ocupado=1, erro_porta=0, counter=TIMEOUT-1.
  - The animator has no reset, so the controller always drives a close first.
- FECHADA: control_port=1, liberar_motor=port_f, ocupado=0.
  - chegou_andar or botao_abrir -> ABRINDO. Counter loads TIMEOUT-1.
  - liberar_motor falls in the same edge that control_port falls.
- ABRINDO: control_port=0.
  - port_a=1 -> ABERTA, counter loads TEMPO_ABERTA-1.
  - Else if counter==0 -> FALHA.
  - Else counter decrements.
- ABERTA: control_port=0. Input priority is obstaculo > botao_abrir > botao_fechar.
  - obstaculo or botao_abrir: reload TEMPO_ABERTA-1, stay.
  - botao_fechar alone: force counter to 0 in the next cycle.
  - counter==0 and obstaculo=0 -> FECHANDO, load TIMEOUT-1. Otherwise decrement.
  - chegou_andar is ignored in this state.
- FECHANDO: control_port=1.
  - obstaculo or botao_abrir or chegou_andar -> ABRINDO (reopen), load TIMEOUT-1. This has priority over port_f in the same cycle.
  - Else port_f=1 -> FECHADA.
  - Else counter==0 -> FALHA. Else decrement.
- FALHA: control_port=0 (fail-safe open), liberar_motor=0, ocupado=1, erro_porta=1. Leaves only on reset.
- Latency: each input-to-control_port decision takes one clock edge.
  - Dwell in ABERTA with no inputs is exactly TEMPO_ABERTA cycles, from the cycle after port_a is sampled to entry into FECHANDO.
- Counter arithmetic is unsigned and never decrements below 0. No wrap.
- port_a and port_f both 1 (illegal): in ABRINDO treat as open, in FECHANDO treat as closed. No fault is raised.

Decomposition:
- Package pkg_porta holds:
  - The state encoding (3-bit localparams EST_FECHADA=0, EST_ABRINDO=1, EST_ABERTA=2, EST_FECHANDO=3, EST_FALHA=4).
  - CMD_ABRIR=0 and CMD_FECHAR=1 for control_port.
- One sub-module, contador_tempo_porta:
  - A loadable LARG_CONT-bit down counter with inputs carregar, valor and decrementar, and outputs valor_atual and zero.
  - Saturates at 0 and resets to TIMEOUT-1.

Test Plan:
- Reset then 10 idle cycles with the door animation block instance connected -> control_port=1 throughout; port_f rises within 5 cycles; state FECHADA, liberar_motor=1, ocupado=0, erro_porta=0.
- From FECHADA, pulse chegou_andar -> next edge control_port=0 and liberar_motor=0. After port_a rises, the door stays open exactly 8 cycles (TEMPO_ABERTA=8). Then control_port=1, and liberar_motor=1 one cycle after port_f.
- During ABERTA hold obstaculo=1 for 20 cycles -> control_port stays 0 for all 20 cycles. Release -> closes 8 cycles later. During ABERTA pulse botao_fechar -> FECHANDO on the second edge after the pulse.
- In FECHANDO (port_f still 0) assert obstaculo for 1 cycle -> control_port=0 on the next edge and state ABRINDO. Assert obstaculo and port_f in the same cycle -> ABRINDO wins.
- Tie port_a=0 in ABRINDO (with TIMEOUT=16) -> erro_porta=1 and state FALHA exactly 16 cycles after entry; control_port=0. Later botao_fechar and chegou_andar have no effect. Asserting reset_n=0 mid-FALHA clears erro_porta asynchronously.

Source files
------------

// File: rtl/pkg_porta.sv
// Shared encodings for the door controller: FSM state codes and door command values.
package pkg_porta;

    localparam logic [2:0] EST_FECHADA  = 3'd0;
    localparam logic [2:0] EST_ABRINDO  = 3'd1;
    localparam logic [2:0] EST_ABERTA   = 3'd2;
    localparam logic [2:0] EST_FECHANDO = 3'd3;
    localparam logic [2:0] EST_FALHA    = 3'd4;

    typedef enum logic [2:0] {
        FECHADA  = EST_FECHADA,
        ABRINDO  = EST_ABRINDO,
        ABERTA   = EST_ABERTA,
        FECHANDO = EST_FECHANDO,
        FALHA    = EST_FALHA
    } estado_t;

    localparam logic CMD_ABRIR  = 1'b0;
    localparam logic CMD_FECHAR = 1'b1;

endpackage

// File: rtl/contador_tempo_porta.sv
// Loadable down counter shared by the dwell and timeout phases; saturates at zero.
module contador_tempo_porta #(
    parameter int unsigned LARG_CONT   = 5,
    parameter int unsigned VALOR_RESET = 15
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 carregar,
    input  logic [LARG_CONT-1:0] valor,
    input  logic                 decrementar,
    output logic [LARG_CONT-1:0] valor_atual,
    output logic                 zero
);

    logic [LARG_CONT-1:0] valor_q;
    logic [LARG_CONT-1:0] valor_d;

    // Load wins over decrement; decrement stops at zero.
    always_comb begin
        valor_d = valor_q;
        if (carregar) begin
            valor_d = valor;
        end else if (decrementar && (valor_q != '0)) begin
            valor_d = valor_q - LARG_CONT'(1);
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            valor_q <= LARG_CONT'(VALOR_RESET);
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor_atual = valor_q;
    assign zero        = (valor_q == '0);

endmodule

// File: rtl/controlador_porta.sv
// Door sequencing FSM: commands the LED animator, waits for its open/closed
// indicators, and only releases the motor once the door is confirmed closed.
module controlador_porta
    import pkg_porta::*;
#(
    parameter int unsigned TEMPO_ABERTA = 8,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic chegou_andar,
    input  logic botao_abrir,
    input  logic botao_fechar,
    input  logic obstaculo,
    input  logic port_a,
    input  logic port_f,
    output logic control_port,
    output logic liberar_motor,
    output logic ocupado,
    output logic erro_porta
);

    localparam int unsigned MAIOR     = (TEMPO_ABERTA > TIMEOUT) ? TEMPO_ABERTA : TIMEOUT;
    localparam int unsigned LARG_CONT = $clog2(MAIOR + 1);

    localparam logic [LARG_CONT-1:0] CARGA_TIMEOUT = LARG_CONT'(TIMEOUT - 1);
    localparam logic [LARG_CONT-1:0] CARGA_ABERTA  = LARG_CONT'(TEMPO_ABERTA - 1);

    estado_t              estado_q;
    estado_t              estado_d;
    logic                 control_q, control_d;
    logic                 liberar_q, liberar_d;
    logic                 ocupado_q, ocupado_d;
    logic                 erro_q,    erro_d;

    logic                 carregar;
    logic [LARG_CONT-1:0] valor_carga;
    logic                 decrementar;
    logic [LARG_CONT-1:0] cont_atual;
    logic                 cont_zero;

    contador_tempo_porta #(
        .LARG_CONT  (LARG_CONT),
        .VALOR_RESET(TIMEOUT - 1)
    ) u_contador (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .carregar   (carregar),
        .valor      (valor_carga),
        .decrementar(decrementar),
        .valor_atual(cont_atual),
        .zero       (cont_zero)
    );

    // Next state and counter control.
    always_comb begin
        estado_d    = estado_q;
        carregar    = 1'b0;
        valor_carga = '0;
        decrementar = 1'b0;
        case (estado_q)
            FECHADA: begin
                if (chegou_andar || botao_abrir) begin
                    estado_d    = ABRINDO;
                    carregar    = 1'b1;
                    valor_carga = CARGA_TIMEOUT;
                end
            end
            ABRINDO: begin
                if (port_a) begin
                    estado_d    = ABERTA;
                    carregar    = 1'b1;
                    valor_carga = CARGA_ABERTA;
                end else if (cont_zero) begin
                    estado_d = FALHA;
                end else begin
                    decrementar = 1'b1;
                end
            end
            ABERTA: begin
                if (obstaculo || botao_abrir) begin
                    carregar    = 1'b1;
                    valor_carga = CARGA_ABERTA;
                end else if (cont_zero) begin
                    estado_d    = FECHANDO;
                    carregar    = 1'b1;
                    valor_carga = CARGA_TIMEOUT;
                end else if (botao_fechar && (cont_atual != '0)) begin
                    // Cut the dwell short: closing starts on the following edge.
                    carregar    = 1'b1;
                    valor_carga = '0;
                end else begin
                    decrementar = 1'b1;
                end
            end
            FECHANDO: begin
                if (obstaculo || botao_abrir || chegou_andar) begin
                    estado_d    = ABRINDO;
                    carregar    = 1'b1;
                    valor_carga = CARGA_TIMEOUT;
                end else if (port_f) begin
                    estado_d = FECHADA;
                end else if (cont_zero) begin
                    estado_d = FALHA;
                end else begin
                    decrementar = 1'b1;
                end
            end
            FALHA:   estado_d = FALHA;
            default: estado_d = FALHA;
        endcase
    end

    // Outputs follow the state being entered so they settle on the same edge.
    always_comb begin
        control_d = CMD_ABRIR;
        if ((estado_d == FECHADA) || (estado_d == FECHANDO)) begin
            control_d = CMD_FECHAR;
        end
        liberar_d = (estado_d == FECHADA) && port_f;
        ocupado_d = (estado_d != FECHADA);
        erro_d    = erro_q || (estado_d == FALHA);
    end

    // Reset drives a close first because the animator itself is not reset.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            estado_q  <= FECHANDO;
            control_q <= CMD_FECHAR;
            liberar_q <= 1'b0;
            ocupado_q <= 1'b1;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            control_q <= control_d;
            liberar_q <= liberar_d;
            ocupado_q <= ocupado_d;
            erro_q    <= erro_d;
        end
    end

    assign control_port  = control_q;
    assign liberar_motor = liberar_q;
    assign ocupado       = ocupado_q;
    assign erro_porta    = erro_q;

endmodule

// File: tb/tb_controlador_porta.sv
// Bench for controlador_porta with a small door animator model and an expected-value queue.
module tb_controlador_porta;

    logic clock_in     = 1'b0;
    logic reset_n      = 1'b0;
    logic chegou_andar = 1'b0;
    logic botao_abrir  = 1'b0;
    logic botao_fechar = 1'b0;
    logic obstaculo    = 1'b0;
    logic port_a, port_f;
    logic control_port, liberar_motor, ocupado, erro_porta;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string      nome;
        logic [3:0] val;
        logic [3:0] mask;
    } exp_t;
    exp_t sb_q[$];
    exp_t e;

    always #5 clock_in = ~clock_in;

    // Animator model: position 0 = closed, 3 = open; manual mode overrides indicators.
    int   pos   = 2;
    logic man   = 1'b0;
    logic man_a = 1'b0;
    logic man_f = 1'b0;

    always @(posedge clock_in) begin
        if (control_port === 1'b1) begin
            if (pos > 0) pos <= pos - 1;
        end else if (pos < 3) begin
            pos <= pos + 1;
        end
    end

    assign port_a = man ? man_a : (pos == 3);
    assign port_f = man ? man_f : (pos == 0);

    controlador_porta dut (
        .clock_in     (clock_in),
        .reset_n      (reset_n),
        .chegou_andar (chegou_andar),
        .botao_abrir  (botao_abrir),
        .botao_fechar (botao_fechar),
        .obstaculo    (obstaculo),
        .port_a       (port_a),
        .port_f       (port_f),
        .control_port (control_port),
        .liberar_motor(liberar_motor),
        .ocupado      (ocupado),
        .erro_porta   (erro_porta)
    );

    function automatic logic [3:0] obs();
        return {control_port, liberar_motor, ocupado, erro_porta};
    endfunction

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic push(input string n, input logic [3:0] v, input logic [3:0] m);
        exp_t x;
        x.nome = n;
        x.val  = v;
        x.mask = m;
        sb_q.push_back(x);
    endtask

    task automatic espera_a(input string n);
        for (int k = 0; k < 20 && !port_a; k++) tick();
        vectors++;
        if (!port_a) begin
            miscompares++;
            $display("FAIL %s: port_a never rose within 20 cycles", n);
        end
    endtask

    task automatic espera_f(input string n);
        for (int k = 0; k < 20 && !port_f; k++) tick();
        vectors++;
        if (!port_f) begin
            miscompares++;
            $display("FAIL %s: port_f never rose within 20 cycles", n);
        end
    endtask

    task automatic abre_porta();
        chegou_andar = 1'b1;
        tick();
        chegou_andar = 1'b0;
        espera_a("abre_porta");
        tick();
    endtask

    task automatic test_reset();
        int first_f;
        reset_n = 1'b0;
        tick();
        tick();
        push("reset_valores", 4'b1010, 4'hF);
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
        reset_n = 1'b1;
        first_f = -1;
        for (int i = 0; i < 10; i++) begin
            push("idle_fecha", 4'b1000, 4'b1000);
            tick();
            e = sb_q.pop_front(); vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                miscompares++;
                $display("FAIL %s: cycle %0d got %b expected %b", e.nome, i, obs(), e.val);
            end
            if (port_f && first_f < 0) first_f = i + 1;
        end
        vectors++;
        if (first_f < 1 || first_f > 5) begin
            miscompares++;
            $display("FAIL idle_port_f: rose at cycle %0d expected within 1..5", first_f);
        end
        push("idle_fechada", 4'b1100, 4'hF);
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
    endtask

    task automatic test_ciclo();
        int n;
        chegou_andar = 1'b1;
        push("chegou_abre", 4'b0010, 4'hF);
        tick();
        chegou_andar = 1'b0;
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
        espera_a("ciclo_port_a");
        tick();
        n = 0;
        while (control_port == 1'b0 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("FAIL ciclo_dwell: door open %0d cycles expected 8", n);
        end
        espera_f("ciclo_port_f");
        push("ciclo_lib_antes", 4'b1010, 4'hF);
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
        push("ciclo_lib_depois", 4'b1100, 4'hF);
        tick();
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
    endtask

    task automatic test_obstaculo();
        int n;
        abre_porta();
        obstaculo = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push("obst_segura", 4'b0010, 4'hF);
            tick();
            e = sb_q.pop_front(); vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                miscompares++;
                $display("FAIL %s: cycle %0d got %b expected %b", e.nome, i, obs(), e.val);
            end
        end
        obstaculo = 1'b0;
        n = 0;
        while (control_port == 1'b0 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("FAIL obst_solta: closed after %0d cycles expected 8", n);
        end
    endtask

    task automatic test_fechar();
        abre_porta();
        botao_fechar = 1'b1;
        push("fechar_1a_borda", 4'b0010, 4'hF);
        tick();
        botao_fechar = 1'b0;
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
        push("fechar_2a_borda", 4'b1010, 4'hF);
        tick();
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
    endtask

    task automatic test_reabre();
        obstaculo = 1'b1;
        push("reabre_obst", 4'b0010, 4'hF);
        tick();
        obstaculo = 1'b0;
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
        espera_a("reabre_port_a");
        tick();
        botao_fechar = 1'b1;
        tick();
        botao_fechar = 1'b0;
        tick();
        man   = 1'b1;
        man_f = 1'b1;
        man_a = 1'b0;
        obstaculo = 1'b1;
        push("reabre_prioridade", 4'b0010, 4'hF);
        tick();
        obstaculo = 1'b0;
        man_f = 1'b0;
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
    endtask

    task automatic test_timeout();
        for (int i = 1; i < 16; i++) begin
            push("timeout_espera", 4'b0010, 4'hF);
            tick();
            e = sb_q.pop_front(); vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                miscompares++;
                $display("FAIL %s: cycle %0d got %b expected %b", e.nome, i, obs(), e.val);
            end
        end
        push("timeout_falha", 4'b0011, 4'hF);
        tick();
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
        botao_fechar = 1'b1;
        chegou_andar = 1'b1;
        tick();
        chegou_andar = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push("falha_retida", 4'b0011, 4'hF);
            tick();
            e = sb_q.pop_front(); vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                miscompares++;
                $display("FAIL %s: cycle %0d got %b expected %b", e.nome, i, obs(), e.val);
            end
        end
        botao_fechar = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        push("reset_assincrono", 4'b1010, 4'hF);
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
        tick();
        reset_n = 1'b1;
        man     = 1'b0;
        for (int k = 0; k < 12 && !liberar_motor; k++) tick();
        push("reset_recupera", 4'b1100, 4'hF);
        e = sb_q.pop_front(); vectors++;
        if ((obs() & e.mask) !== (e.val & e.mask)) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.nome, obs(), e.val);
        end
    endtask

    initial begin
        test_reset();
        test_ciclo();
        test_obstaculo();
        test_fechar();
        test_reabre();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
